// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
//   Shared definitions for the register-file dump reader: bus geometry,
//   FSM state encoding and the helper that extracts one register from the
//   packed check bus (r[0] sits in the most significant word).
package reg_dump_pkg;

    localparam int NREGS = 32;
    localparam int DW    = 32;
    localparam int IDXW  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic [DW-1:0] word_at(input logic [NREGS*DW-1:0] bus,
                                              input logic [IDXW-1:0]     idx);
        return bus[(NREGS - 1 - int'(idx)) * DW +: DW];
    endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Snapshots the register file's debug check bus on a start pulse and
//   streams the registers out as (index, data) words over valid/ready.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      request one dump (sampled only in IDLE)
//   check      packed register file bus, r[0] in the top word
//   out_ready  downstream accepts the current word
//   out_valid  out_index/out_data hold a word
//   out_index  register number of the current word
//   out_data   snapshot value of register out_index
//   busy       dump in progress
//   done       one-cycle pulse once the last register is accepted/skipped
//
// State table
//   state | meaning
//   IDLE  | waiting for start; outputs quiet
//   SEND  | presenting snap[ptr], advancing on accept or zero-skip
//   FIN   | single-cycle done pulse, then back to IDLE
module reg_dump_reader #(
    parameter int NREGS     = 32,
    parameter int DW        = 32,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NREGS*DW-1:0] check,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [4:0]          out_index,
    output logic [DW-1:0]       out_data,
    output logic                busy,
    output logic                done
);
    import reg_dump_pkg::*;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);

    state_t              state, state_d;
    logic [IDXW-1:0]     ptr, ptr_d;
    logic [NREGS*DW-1:0] snap;
    logic [DW-1:0]       cur_word;
    logic                skip;
    logic                load;

    assign load     = (state == IDLE) && start;
    assign cur_word = word_at(snap, ptr);
    assign skip     = SKIP_ZERO && (cur_word == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
        end
    end

    // Snapshot has no reset value; it is always reloaded before use.
    always_ff @(posedge clk) begin
        if (load) begin
            snap <= check;
        end
    end

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        out_valid = 1'b0;
        out_index = '0;
        out_data  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    ptr_d   = '0;
                end
            end
            SEND: begin
                busy = 1'b1;
                if (!skip) begin
                    out_valid = 1'b1;
                    out_index = ptr;
                    out_data  = cur_word;
                end
                // ptr only moves on accept, so index/data stay stable under backpressure.
                if (skip || out_ready) begin
                    if (ptr == LAST_IDX) begin
                        state_d = FIN;
                    end else begin
                        ptr_d = ptr + 1'b1;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

    typedef struct {
        bit          start;
        bit          ready;
        bit          exp_valid;
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
        bit          exp_busy;
        bit          exp_done;
    } row_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start0, start1;
    logic          out_ready;
    logic [1023:0] check;

    logic          v0, v1, b0, b1, dn0, dn1;
    logic [4:0]    i0, i1;
    logic [31:0]   d0, d1;

    int compared   = 0;
    int mismatched = 0;

    row_t rows[64];
    int   nrows;

    always #5 clk = ~clk;

    reg_dump_reader #(.NREGS(32), .DW(32), .SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .check(check), .out_ready(out_ready),
        .out_valid(v0), .out_index(i0), .out_data(d0), .busy(b0), .done(dn0)
    );

    reg_dump_reader #(.NREGS(32), .DW(32), .SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .check(check), .out_ready(out_ready),
        .out_valid(v1), .out_index(i1), .out_data(d1), .busy(b1), .done(dn1)
    );

    function automatic logic [31:0] rval(input int i);
        return 32'(i * 16 + 1);
    endfunction

    task automatic set_reg(input int i, input logic [31:0] v);
        check[(31 - i) * 32 +: 32] = v;
    endtask

    task automatic add(input bit s, input bit rdy, input bit v, input int idx,
                       input logic [31:0] d, input bit b, input bit dn);
        rows[nrows].start     = s;
        rows[nrows].ready     = rdy;
        rows[nrows].exp_valid = v;
        rows[nrows].exp_idx   = 5'(idx);
        rows[nrows].exp_data  = d;
        rows[nrows].exp_busy  = b;
        rows[nrows].exp_done  = dn;
        nrows++;
    endtask

    task automatic check_now(input string name, input bit sel, input bit ev,
                             input logic [4:0] ei, input logic [31:0] ed,
                             input bit eb, input bit edn);
        logic        av, ab, adn;
        logic [4:0]  ai;
        logic [31:0] ad;
        av  = sel ? v1  : v0;
        ai  = sel ? i1  : i0;
        ad  = sel ? d1  : d0;
        ab  = sel ? b1  : b0;
        adn = sel ? dn1 : dn0;
        compared++;
        if (av !== ev || ai !== ei || ad !== ed || ab !== eb || adn !== edn) begin
            mismatched++;
            $display("FAIL %s: got v=%0b idx=%0d data=%h busy=%0b done=%0b, want v=%0b idx=%0d data=%h busy=%0b done=%0b",
                     name, av, ai, ad, ab, adn, ev, ei, ed, eb, edn);
        end
    endtask

    // Caller is at a negedge; each row drives inputs, checks, then advances one cycle.
    task automatic run_rows(input string name, input bit sel);
        for (int r = 0; r < nrows; r++) begin
            out_ready = rows[r].ready;
            if (sel) start1 = rows[r].start;
            else     start0 = rows[r].start;
            #1;
            check_now($sformatf("%s[%0d]", name, r), sel, rows[r].exp_valid, rows[r].exp_idx,
                      rows[r].exp_data, rows[r].exp_busy, rows[r].exp_done);
            @(negedge clk);
        end
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start1 = 1'b1;
        else     start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start0    = 1'b0;
        start1    = 1'b0;
        out_ready = 1'b1;
        check     = '0;
        repeat (3) @(negedge clk);
        #1;
        check_now("reset0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        check_now("reset1", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic dump with backpressure on index 5, snapshot freeze on r[10],
        // start ignored during SEND and FIN.
        for (int i = 0; i < 32; i++) set_reg(i, rval(i));
        nrows = 0;
        for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 1'b1, k, rval(k), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b1, 5, 32'h51, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 5, 32'h51, 1'b1, 1'b0);
        for (int k = 6; k < 32; k++) add(k == 20, 1'b1, 1'b1, k, rval(k), 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        pulse_start(1'b0);
        set_reg(10, 32'hDEAD);
        run_rows("dump", 1'b0);

        // Skip-zero: only r[29] nonzero; done visible 32 cycles after start edge.
        check = '0;
        set_reg(29, 32'd2047);
        nrows = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == 29) add(1'b0, 1'b1, 1'b1, 29, 32'h7FF, 1'b1, 1'b0);
            else         add(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        end
        add(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        pulse_start(1'b1);
        run_rows("skip", 1'b1);

        // Reset mid-dump at index 12.
        for (int i = 0; i < 32; i++) set_reg(i, rval(i));
        pulse_start(1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k == 12) rst = 1'b1;
            #1;
            check_now($sformatf("pre_rst[%0d]", k), 1'b0, 1'b1, 5'(k), rval(k), 1'b1, 1'b0);
            @(negedge clk);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_now($sformatf("post_rst[%0d]", k), 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Reset wins over start on the same edge.
        rst    = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_now($sformatf("rst_vs_start[%0d]", k), 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Fresh dump after reset still works: first word visible.
        pulse_start(1'b0);
        #1;
        check_now("restart", 1'b0, 1'b1, 5'd0, rval(0), 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
